// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box audio path.
package music_box_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam logic [7:0] SAMPLE_MIDSCALE = 8'd128;
  localparam logic [7:0] ENV_MAX         = 8'd255;

endpackage

// File: rtl/envelope_adsr_if.sv
// Sample/gate bundle between the waveform generator, the envelope stage and the mixer.
interface envelope_adsr_if;
  logic       noteOn;
  logic [7:0] sustainLevel;
  logic [7:0] inputSample;
  logic       indexZero;
  logic [7:0] outputSample;
  logic [7:0] envelopeLevel;
  logic       active;

  modport master (
    output noteOn, sustainLevel, inputSample, indexZero,
    input  outputSample, envelopeLevel, active
  );

  modport slave (
    input  noteOn, sustainLevel, inputSample, indexZero,
    output outputSample, envelopeLevel, active
  );
endinterface

// File: rtl/envelope_scaler.sv
// Scales an unsigned sample about midscale by an 8-bit envelope; purely combinational.
module envelope_scaler
  import music_box_pkg::*;
(
  input  logic [7:0] i_sample,
  input  logic [7:0] i_env,
  output logic [7:0] o_y
);

  logic signed [8:0]  w_s;
  logic signed [17:0] w_s_ext;
  logic signed [17:0] w_env_ext;
  logic signed [17:0] w_p;
  logic signed [9:0]  w_sh;
  logic signed [10:0] w_y;

  assign w_s       = {1'b0, i_sample} - {1'b0, SAMPLE_MIDSCALE};
  assign w_s_ext   = 18'(w_s);
  assign w_env_ext = {10'd0, i_env};
  assign w_p       = w_s_ext * w_env_ext;
  // Top bits of the product are the arithmetic shift by 8 (floor toward -inf)
  assign w_sh      = w_p[17:8];
  assign w_y       = 11'(w_sh) + 11'sd128;

  always_comb begin
    o_y = w_y[7:0];
    if (w_y < 11'sd0)
      o_y = 8'd0;
    else if (w_y > 11'sd255)
      o_y = 8'd255;
  end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR amplitude envelope with registered scaled output.
// Optional ENVELOPE_ZERO_CROSS_EN: note start from IDLE waits for the generator phase-zero strobe.
//
// state   | meaning
// IDLE    | silent, env held at 0, waiting for gate
// ATTACK  | env rising by ATTACK_STEP per tick up to 255
// DECAY   | env falling by DECAY_STEP per tick down to sustainLevel
// SUSTAIN | env follows sustainLevel at tick rate
// RELEASE | gate low, env falling by RELEASE_STEP per tick to 0
module envelope_adsr
  import music_box_pkg::*;
#(
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned DECAY_STEP   = 1,
  parameter int unsigned RELEASE_STEP = 2,
  parameter int unsigned TICK_DIV     = 32
) (
  input  logic            CLK_32KHz,
  input  logic            reset_n,
  envelope_adsr_if.slave  bus
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0] A_STEP = 8'(ATTACK_STEP);
  localparam logic [7:0] D_STEP = 8'(DECAY_STEP);
  localparam logic [7:0] R_STEP = 8'(RELEASE_STEP);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_ATTACK  = ATTACK;
  localparam logic [2:0] S_DECAY   = DECAY;
  localparam logic [2:0] S_SUSTAIN = SUSTAIN;
  localparam logic [2:0] S_RELEASE = RELEASE;

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_state;
  logic [7:0]        r_env;
  logic [7:0]        r_out;
  logic [2:0]        w_state_nxt;
  logic [7:0]        w_env_nxt;
  logic [7:0]        w_y;
  logic              w_tick;
  logic              w_start;
  logic [8:0]        w_att_sum;
  logic signed [9:0] w_dec_diff;

`ifdef ENVELOPE_ZERO_CROSS_EN
  assign w_start = bus.noteOn & bus.indexZero;
`else
  logic w_unused_index_zero;
  assign w_unused_index_zero = bus.indexZero;
  assign w_start = bus.noteOn;
`endif

  assign w_tick     = (r_cnt == CNT_LAST);
  assign w_att_sum  = {1'b0, r_env} + {1'b0, A_STEP};
  assign w_dec_diff = {2'b00, r_env} - {2'b00, D_STEP};

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Gate changes win over the tick: state moves, env holds for that cycle
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    case (r_state)
      S_IDLE: begin
        w_env_nxt = 8'd0;
        if (w_start)
          w_state_nxt = S_ATTACK;
      end
      S_ATTACK: begin
        if (!bus.noteOn)
          w_state_nxt = S_RELEASE;
        else if (w_tick) begin
          if (w_att_sum >= {1'b0, ENV_MAX}) begin
            w_env_nxt   = ENV_MAX;
            w_state_nxt = S_DECAY;
          end else
            w_env_nxt = w_att_sum[7:0];
        end
      end
      S_DECAY: begin
        if (!bus.noteOn)
          w_state_nxt = S_RELEASE;
        else if (w_tick) begin
          if (w_dec_diff <= $signed({2'b00, bus.sustainLevel})) begin
            w_env_nxt   = bus.sustainLevel;
            w_state_nxt = S_SUSTAIN;
          end else
            w_env_nxt = w_dec_diff[7:0];
        end
      end
      S_SUSTAIN: begin
        if (!bus.noteOn)
          w_state_nxt = S_RELEASE;
        else if (w_tick)
          w_env_nxt = bus.sustainLevel;
      end
      S_RELEASE: begin
        if (bus.noteOn)
          w_state_nxt = S_ATTACK;
        else if (w_tick) begin
          if (r_env <= R_STEP) begin
            w_env_nxt   = 8'd0;
            w_state_nxt = S_IDLE;
          end else
            w_env_nxt = r_env - R_STEP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_env_nxt   = 8'd0;
      end
    endcase
  end

  envelope_scaler u_scaler (
    .i_sample (bus.inputSample),
    .i_env    (r_env),
    .o_y      (w_y)
  );

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_env   <= 8'd0;
      r_out   <= SAMPLE_MIDSCALE;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
      r_out   <= w_y;
    end
  end

  assign bus.outputSample  = r_out;
  assign bus.envelopeLevel = r_env;
  assign bus.active        = (r_state != S_IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// Scoreboard bench for envelope_adsr: stimulus queues expected outputs, a negedge monitor compares.
module tb_envelope_adsr;
  import music_box_pkg::*;

  localparam int TDIV = 32;

  typedef struct {
    string      name;
    bit         chk_out;
    logic [7:0] out;
    logic [7:0] env;
    logic       act;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];
  exp_t x;

  always #5 clk = ~clk;

  envelope_adsr_if bus ();

  envelope_adsr #(
    .ATTACK_STEP  (4),
    .DECAY_STEP   (1),
    .RELEASE_STEP (2),
    .TICK_DIV     (TDIV)
  ) dut (
    .CLK_32KHz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  always @(negedge clk) begin
    while (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (bus.envelopeLevel !== x.env) begin
        errors++;
        $display("FAIL %s envelopeLevel got %0d want %0d", x.name, bus.envelopeLevel, x.env);
      end
      checks++;
      if (bus.active !== x.act) begin
        errors++;
        $display("FAIL %s active got %0b want %0b", x.name, bus.active, x.act);
      end
      if (x.chk_out) begin
        checks++;
        if (bus.outputSample !== x.out) begin
          errors++;
          $display("FAIL %s outputSample got %0d want %0d", x.name, bus.outputSample, x.out);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  // Advance until just after the n-th upcoming tick edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do step(1); while (cyc % TDIV != 0);
    end
  endtask

  task automatic exp_st(input string nm, input logic [7:0] e, input logic a);
    exp_t t;
    t.name = nm; t.chk_out = 1'b0; t.out = 8'd0; t.env = e; t.act = a;
    q.push_back(t);
  endtask

  task automatic exp_all(input string nm, input logic [7:0] o, input logic [7:0] e, input logic a);
    exp_t t;
    t.name = nm; t.chk_out = 1'b1; t.out = o; t.env = e; t.act = a;
    q.push_back(t);
  endtask

  task automatic start_note();
    bus.noteOn    = 1'b1;
    bus.indexZero = 1'b1;
    step(1);
    bus.indexZero = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.noteOn       = 1'b0;
    bus.sustainLevel = 8'd128;
    bus.inputSample  = 8'd200;
    bus.indexZero    = 1'b0;
    #2;
    exp_all("reset", 8'd128, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    for (int i = 0; i < 10; i++) begin
      step(100);
      exp_all("idle_hold", 8'd128, 8'd0, 1'b0);
    end

    // full ADSR at defaults
    bus.inputSample = 8'd255;
    start_note();
    exp_st("attack_start", 8'd0, 1'b1);
    wait_ticks(63);
    exp_st("attack_63", 8'd252, 1'b1);
    wait_ticks(1);
    exp_all("attack_top", 8'd253, 8'd255, 1'b1);
    step(1);
    exp_all("out_max", 8'd254, 8'd255, 1'b1);
    bus.inputSample = 8'd0;
    step(1);
    exp_all("out_min", 8'd0, 8'd255, 1'b1);
    bus.inputSample = 8'd255;
    wait_ticks(126);
    exp_st("decay_126", 8'd129, 1'b1);
    wait_ticks(1);
    exp_st("decay_to_sus", 8'd128, 1'b1);
    step(1);
    exp_all("sus_out_hi", 8'd191, 8'd128, 1'b1);
    bus.inputSample = 8'd0;
    step(1);
    exp_all("sus_out_lo", 8'd64, 8'd128, 1'b1);
    bus.inputSample = 8'd128;
    step(1);
    exp_all("sus_out_mid", 8'd128, 8'd128, 1'b1);
    bus.inputSample = 8'd255;

    bus.sustainLevel = 8'd100;
    step(1);
    exp_st("sus_no_tick", 8'd128, 1'b1);
    wait_ticks(1);
    exp_st("sus_track", 8'd100, 1'b1);
    bus.sustainLevel = 8'd128;
    wait_ticks(1);
    exp_st("sus_back", 8'd128, 1'b1);

    // release to idle
    bus.noteOn = 1'b0;
    step(1);
    exp_st("rel_hold", 8'd128, 1'b1);
    wait_ticks(63);
    exp_st("rel_63", 8'd2, 1'b1);
    wait_ticks(1);
    exp_st("rel_end", 8'd0, 1'b0);
    step(1);
    exp_all("rel_idle_out", 8'd128, 8'd0, 1'b0);
    step(200);
    exp_st("idle_after", 8'd0, 1'b0);

    // retrigger from release at env=100
    start_note();
    wait_ticks(25);
    exp_st("att_100", 8'd100, 1'b1);
    bus.noteOn = 1'b0;
    step(1);
    exp_st("rel_100", 8'd100, 1'b1);
    bus.noteOn = 1'b1;
    step(1);
    exp_st("retrig", 8'd100, 1'b1);
    wait_ticks(1);
    exp_st("retrig_tick", 8'd104, 1'b1);
    wait_ticks(38);
    exp_st("att2_top", 8'd255, 1'b1);
    wait_ticks(55);
    exp_st("decay_200", 8'd200, 1'b1);

    // gate fall on the same edge as a tick
    step(31);
    bus.noteOn = 1'b0;
    step(1);
    exp_st("gate_tick", 8'd200, 1'b1);
    wait_ticks(1);
    exp_st("rel_198", 8'd198, 1'b1);

    // asynchronous reset mid-note
    step(5);
    rst_n = 1'b0;
    #1;
    exp_all("async_rst", 8'd128, 8'd0, 1'b0);
    step(2);
    rst_n = 1'b1;
    cyc   = 0;

    // note start with indexZero held low for 500 cycles
    bus.noteOn = 1'b1;
    step(1);
`ifdef ENVELOPE_ZERO_CROSS_EN
    exp_st("zc_start", 8'd0, 1'b0);
    step(30);
    exp_st("zc_pre_tick", 8'd0, 1'b0);
    step(1);
    exp_st("zc_first_tick", 8'd0, 1'b0);
    step(468);
    exp_st("zc_500", 8'd0, 1'b0);
    bus.indexZero = 1'b1;
    step(1);
    bus.indexZero = 1'b0;
    exp_st("zc_pulse", 8'd0, 1'b1);
    wait_ticks(1);
    exp_st("zc_tick", 8'd4, 1'b1);
`else
    exp_st("zc_start", 8'd0, 1'b1);
    step(30);
    exp_st("zc_pre_tick", 8'd0, 1'b1);
    step(1);
    exp_st("zc_first_tick", 8'd4, 1'b1);
    step(468);
    exp_st("zc_500", 8'd60, 1'b1);
    bus.indexZero = 1'b1;
    step(1);
    bus.indexZero = 1'b0;
    exp_st("zc_pulse", 8'd60, 1'b1);
    wait_ticks(1);
    exp_st("zc_tick", 8'd64, 1'b1);
`endif

    step(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_adsr.md
# envelope_adsr

Amplitude-envelope stage sitting directly downstream of the waveform generators (sine/square/triangle) on the 32 kHz audio clock. It takes the generator's unsigned 8-bit sample and its phase-zero strobe, runs an attack/decay/sustain/release state machine driven by a note gate, and emits the sample scaled about midscale (128) by the current envelope level. The output feeds the mixer/PWM output stage.

## Interface
- ATTACK_STEP, 4: envelope increment per tick in ATTACK (1..255)
- DECAY_STEP, 1: envelope decrement per tick in DECAY (1..255)
- RELEASE_STEP, 2: envelope decrement per tick in RELEASE (1..255)
- TICK_DIV, 32: clock cycles per envelope tick (2..256); default gives 1 ms tick
- CLK_32KHz  in  1  sample clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- noteOn  in  1  note gate, level-sensitive, synchronous to CLK_32KHz
- sustainLevel  in  8  sustain envelope level, 0..255
- inputSample  in  8  unsigned generator sample, 128 = silence
- indexZero  in  1  generator phase-zero strobe
- outputSample  out  8  scaled unsigned sample
- envelopeLevel  out  8  current envelope value
- active  out  1  high whenever state != IDLE

## Operation
- Reset values: state IDLE, envelope 0, tick counter 0, outputSample 8'd128, envelopeLevel 0, active 0.
- Tick counter free-runs 0..TICK_DIV-1 from reset; tick = (counter == TICK_DIV-1). Envelope changes only on ticks, except where noted below.
- States and transitions:
  - IDLE: env = 0. noteOn=1 -> ATTACK next cycle.
  - ATTACK: on tick, env + ATTACK_STEP >= 255 -> env = 255, go DECAY; else env += ATTACK_STEP.
  - DECAY: on tick, env - DECAY_STEP <= sustainLevel (signed compare, no underflow) -> env = sustainLevel, go SUSTAIN; else env -= DECAY_STEP.
  - SUSTAIN: on tick, env = sustainLevel, so a change to sustainLevel is tracked at tick rate.
  - RELEASE: on tick, env <= RELEASE_STEP -> env = 0, go IDLE; else env -= RELEASE_STEP.
- In ATTACK, DECAY or SUSTAIN, noteOn=0 -> RELEASE next cycle, env held.
- In RELEASE, noteOn=1 -> ATTACK next cycle, starting from the current env (retrigger without jump to zero).
- Gate transitions take priority over the tick. When a gate transition and a tick coincide, the state changes and env is unchanged that cycle.
- Scaling:
  - s = inputSample - 128 (9-bit signed).
  - p = s * {1'b0, env} (18-bit signed).
  - y = (p >>> 8) + 128, saturated to 0..255.
  - env = 0 gives 128. env = 255 with inputSample = 255 gives 254.
- No arithmetic wrap is permitted anywhere. All env updates saturate at 0 and 255.

## Timing
- outputSample is registered: 1-cycle latency from inputSample, using env as registered in the same cycle.
- envelopeLevel and active are registered state; they reflect the state and env after the last edge.
- Full attack at defaults: 64 ticks = 2048 cycles from 0 to 255.
- Reset asserted mid-note forces IDLE/0/128 immediately (asynchronously). After release of reset, the first tick is TICK_DIV cycles later.

## Configuration
- ENVELOPE_ZERO_CROSS_EN:
  - Defined: the IDLE -> ATTACK transition occurs only in a cycle where noteOn=1 and indexZero=1. Until then the block stays in IDLE with active=0. This gives click-free note starts.
  - Undefined: indexZero is ignored and IDLE -> ATTACK occurs on the first cycle with noteOn=1.
  - The RELEASE -> ATTACK retrigger is never gated.

## Structure
- Shared package music_box_pkg holds:
  - env_state_t enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}
  - SAMPLE_MIDSCALE = 8'd128
  - ENV_MAX = 8'd255
- One sub-module, envelope_scaler: combinational signed multiply, shift and saturate (inputSample, env -> y). It is instantiated once; the output register stays in envelope_adsr.

## Test plan
- Reset with inputSample=200 -> outputSample=128, envelopeLevel=0, active=0. These values hold with noteOn=0 for 1000 cycles.
- Defaults, sustainLevel=128, noteOn rises:
  - env reaches 255 at tick 64.
  - env then decays by 1 per tick to 128 and enters SUSTAIN.
  - With inputSample=255 held in sustain, outputSample=191.
- In SUSTAIN (env=128), noteOn falls:
  - RELEASE, env reaches 0 after 64 ticks, then IDLE, active=0, outputSample=128.
- In RELEASE at env=100, noteOn rises -> ATTACK continues from 100 (next tick 104) and does not restart from 0.
- With ENVELOPE_ZERO_CROSS_EN and noteOn held high, indexZero pulsed 500 cycles later -> state stays IDLE (active=0) until the cycle after the pulse. Without the macro, ATTACK begins the cycle after noteOn.
- Gate fall coincident with a tick in DECAY at env=200 -> next cycle RELEASE with env=200, unchanged.
